// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch sequencer: owns the fetch PC, absorbs imem misses and
// stalls, and buffers EX redirects that land while an access is in flight.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_busywait,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        imem_read,
  output logic        if_valid,
  output logic        flush_ifid,
  output logic        misalign
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    MISS  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc_nx;
  logic        pend_valid;
  logic        pend_valid_nx;
  logic [31:0] pend_target;
  logic [31:0] pend_target_nx;
  logic [31:0] tgt;

  logic br_hit;
  logic br_miss;
  logic wait_miss;
  logic pend_apply;
  logic hold_stall;

  assign tgt      = {branch_target[31:2], 2'b00};
  assign pc_plus4 = pc_out + 32'd4;

  // One-hot view of the priority rules so the decoder can be unique
  assign br_hit     = branch_taken & ~imem_busywait;
  assign br_miss    = branch_taken & imem_busywait;
  assign wait_miss  = ~branch_taken & imem_busywait;
  assign pend_apply = ~branch_taken & ~imem_busywait & pend_valid;
  assign hold_stall = ~branch_taken & ~imem_busywait
                    & ~pend_valid & stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      pc_out      <= RESET_VECTOR;
      imem_read   <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else begin
      state       <= state_nx;
      pc_out      <= pc_nx;
      imem_read   <= 1'b1;
      pend_valid  <= pend_valid_nx;
      pend_target <= pend_target_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    pc_nx          = pc_out;
    pend_valid_nx  = pend_valid;
    pend_target_nx = pend_target;
    if_valid       = 1'b0;
    flush_ifid     = 1'b0;
    misalign       = 1'b0;
    if (state == BOOT) begin
      state_nx = FETCH;
    end else begin
      misalign = branch_taken & (|branch_target[1:0]);
      unique case (1'b1)
        br_hit: begin
          pc_nx         = tgt;
          pend_valid_nx = 1'b0;
          flush_ifid    = 1'b1;
          state_nx      = FETCH;
        end
        br_miss: begin
          pend_target_nx = tgt;
          pend_valid_nx  = 1'b1;
          flush_ifid     = 1'b1;
          state_nx       = MISS;
        end
        wait_miss: begin
          state_nx = MISS;
        end
        // Access completed: squash the returned word, jump to buffered target
        pend_apply: begin
          pc_nx         = pend_target;
          pend_valid_nx = 1'b0;
          flush_ifid    = 1'b1;
          state_nx      = FETCH;
        end
        hold_stall: begin
          state_nx = FETCH;
        end
        default: begin
          pc_nx    = pc_plus4;
          if_valid = 1'b1;
          state_nx = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: directed vector table, then random
// traffic against a rule-level reference model.
module tb_pc_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic        imem_busywait;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        imem_read;
  logic        if_valid;
  logic        flush_ifid;
  logic        misalign;

  int checks;
  int failures;

  pc_fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .imem_busywait (imem_busywait),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .imem_read     (imem_read),
    .if_valid      (if_valid),
    .flush_ifid    (flush_ifid),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        busy;
    logic        stall;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        rd;
    logic        ifv;
    logic        fl;
    logic        mis;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic r, input logic b, input logic s,
                     input logic t, input logic [31:0] g,
                     input logic [31:0] p, input logic rd,
                     input logic iv, input logic f, input logic m);
    vec_t e;
    e.rst = r; e.busy = b; e.stall = s; e.bt = t; e.tgt = g;
    e.pc = p; e.rd = rd; e.ifv = iv; e.fl = f; e.mis = m;
    tv.push_back(e);
  endtask

  task automatic drive(input logic r, input logic b, input logic s,
                       input logic t, input logic [31:0] g);
    rst = r; imem_busywait = b; stall = s;
    branch_taken = t; branch_target = g;
  endtask

  task automatic check(input string name, input logic [31:0] p,
                       input logic rd, input logic iv, input logic f,
                       input logic m);
    logic [31:0] p4;
    p4 = p + 32'd4;
    checks++;
    if (pc_out !== p || pc_plus4 !== p4 || imem_read !== rd ||
        if_valid !== iv || flush_ifid !== f || misalign !== m) begin
      failures++;
      $display("FAIL %s: got pc=%h p4=%h rd=%b ifv=%b fl=%b mis=%b want pc=%h p4=%h rd=%b ifv=%b fl=%b mis=%b",
               name, pc_out, pc_plus4, imem_read, if_valid, flush_ifid,
               misalign, p, p4, rd, iv, f, m);
    end
  endtask

  // Reference model state: running=0 means still in the boot cycle
  logic        m_running;
  logic        m_rd;
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_ptgt;

  task automatic model_reset();
    m_running = 1'b0; m_rd = 1'b0; m_pc = 32'h0;
    m_pend = 1'b0; m_ptgt = 32'h0;
  endtask

  task automatic model_expect(output logic iv, output logic f,
                              output logic m);
    iv = 1'b0; f = 1'b0; m = 1'b0;
    if (m_running) begin
      m  = branch_taken && (branch_target % 4 != 0);
      f  = branch_taken || (!imem_busywait && m_pend);
      iv = !branch_taken && !imem_busywait && !m_pend && !stall;
    end
  endtask

  task automatic model_step();
    logic [31:0] aligned;
    aligned = branch_target - (branch_target % 4);
    if (!rst) begin
      model_reset();
    end else if (!m_running) begin
      m_running = 1'b1; m_rd = 1'b1;
    end else if (branch_taken && imem_busywait) begin
      m_pend = 1'b1; m_ptgt = aligned;
    end else if (branch_taken) begin
      m_pc = aligned; m_pend = 1'b0;
    end else if (imem_busywait) begin
      m_pc = m_pc;
    end else if (m_pend) begin
      m_pc = m_ptgt; m_pend = 1'b0;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  initial begin
    logic iv, f, m;
    logic [31:0] g;
    checks = 0;
    failures = 0;

    // rst bu st bt tgt            pc            rd iv fl mi
    add(0, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h4,        1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h8,        1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'hC,        1, 1, 0, 0);
    add(1, 1, 0, 0, 32'h0,        32'h10,       1, 0, 0, 0);
    add(1, 1, 0, 0, 32'h0,        32'h10,       1, 0, 0, 0);
    add(1, 1, 0, 0, 32'h0,        32'h10,       1, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h10,       1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h14,       1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h18,       1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h1C,       1, 1, 0, 0);
    add(1, 0, 0, 1, 32'h100,      32'h20,       1, 0, 1, 0);
    add(1, 0, 0, 0, 32'h0,        32'h100,      1, 1, 0, 0);
    add(1, 0, 0, 1, 32'h40,       32'h104,      1, 0, 1, 0);
    add(1, 1, 0, 0, 32'h0,        32'h40,       1, 0, 0, 0);
    add(1, 1, 0, 1, 32'h200,      32'h40,       1, 0, 1, 0);
    add(1, 1, 0, 1, 32'h300,      32'h40,       1, 0, 1, 0);
    add(1, 1, 0, 0, 32'h0,        32'h40,       1, 0, 0, 0);
    add(1, 1, 0, 0, 32'h0,        32'h40,       1, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h40,       1, 0, 1, 0);
    add(1, 0, 0, 0, 32'h0,        32'h300,      1, 1, 0, 0);
    add(1, 0, 0, 1, 32'h50,       32'h304,      1, 0, 1, 0);
    add(1, 0, 1, 0, 32'h0,        32'h50,       1, 0, 0, 0);
    add(1, 0, 1, 0, 32'h0,        32'h50,       1, 0, 0, 0);
    add(1, 0, 1, 1, 32'h83,       32'h50,       1, 0, 1, 1);
    add(1, 0, 0, 0, 32'h0,        32'h80,       1, 1, 0, 0);
    add(1, 0, 0, 1, 32'hFFFF_FFFC, 32'h84,      1, 0, 1, 0);
    add(1, 0, 0, 0, 32'h0,        32'hFFFF_FFFC, 1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0);
    add(1, 1, 0, 0, 32'h0,        32'h4,        1, 0, 0, 0);
    add(1, 1, 0, 1, 32'h500,      32'h4,        1, 0, 1, 0);
    add(0, 1, 0, 0, 32'h0,        32'h4,        1, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0,        0, 0, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h0,        1, 1, 0, 0);
    add(1, 0, 0, 0, 32'h0,        32'h4,        1, 1, 0, 0);

    drive(0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].busy, tv[i].stall, tv[i].bt, tv[i].tgt);
      @(negedge clk);
      check($sformatf("vec%0d", i), tv[i].pc, tv[i].rd,
            tv[i].ifv, tv[i].fl, tv[i].mis);
      @(posedge clk);
      #1;
    end

    drive(0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      g = $urandom;
      if ($urandom_range(0, 1) == 0) g[1:0] = 2'b00;
      drive($urandom_range(0, 99) >= 2,
            $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 15,
            $urandom_range(0, 99) < 15, g);
      @(negedge clk);
      model_expect(iv, f, m);
      check($sformatf("rand%0d", n), m_pc, m_rd, iv, f, m);
      model_step();
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Fetch sequencer for the IF stage of the RV32IM pipeline. Owns the fetch program counter and decides each cycle whether it advances by 4, holds for an instruction-memory miss or a hazard stall, or redirects to a branch/jump target from EX. Redirects that arrive while an instruction-memory access is in flight are buffered and applied when the access completes. Drives the instruction-memory read strobe and the IF/ID load/flush controls.

## Interface
- RESET_VECTOR, 32'h0000_0000, fetch address loaded on reset

- clk  input  1  system clock; all state updates on posedge
- rst  input  1  synchronous, active-low reset: rst == 0 at a posedge resets the block
- imem_busywait  input  1  instruction memory busy; the access at pc_out has not completed this cycle
- stall  input  1  hazard-unit stall; IF/ID must hold and PC must not advance
- branch_taken  input  1  redirect request from EX, valid for one cycle
- branch_target  input  32  redirect address, qualified by branch_taken
- pc_out  output  32  current fetch address (registered)
- pc_plus4  output  32  pc_out + 4, modulo 2^32 (combinational)
- imem_read  output  1  read strobe to instruction memory (registered)
- if_valid  output  1  fetched word at pc_out is valid and IF/ID may load it this cycle
- flush_ifid  output  1  IF/ID must load a bubble this cycle
- misalign  output  1  one-cycle pulse: the accepted redirect target had bits [1:0] != 0

## Operation
- States: BOOT, FETCH, MISS. A pending-redirect register holds pend_valid and pend_target[31:0].
- Reset (rst == 0 at a posedge): state BOOT, pc_out = RESET_VECTOR, imem_read = 0, pend_valid = 0, pend_target = 0. While in BOOT, if_valid = 0, flush_ifid = 0, misalign = 0. Reset overrides every other input, including during MISS or with a redirect pending.
- BOOT -> FETCH on the next posedge; imem_read becomes 1 and stays 1 in FETCH and MISS.
- Redirect target handling: the stored target is {branch_target[31:2], 2'b00}. misalign = branch_taken & (branch_target[1:0] != 0), valid in the cycle the redirect is accepted.
- In FETCH or MISS, each cycle is decided by the first matching rule:
  1. branch_taken & !imem_busywait: pc_out <= target; pend_valid <= 0; flush_ifid = 1; if_valid = 0; state FETCH.
  2. branch_taken & imem_busywait: pend_target <= target; pend_valid <= 1; pc_out held; flush_ifid = 1; state MISS. The in-flight access is not abandoned.
  3. imem_busywait: pc_out held; if_valid = 0; state MISS.
  4. pend_valid (the access just completed): pc_out <= pend_target; pend_valid <= 0; if_valid = 0, so the returned word is squashed; flush_ifid = 1; state FETCH.
  5. stall: pc_out held; if_valid = 0; flush_ifid = 0; state FETCH.
  6. Otherwise: pc_out <= pc_plus4; if_valid = 1; state FETCH.
- A new redirect while pend_valid = 1 overwrites pend_target; the youngest redirect wins.
- When branch_taken and stall are both asserted, the redirect wins and the stall is ignored for PC purposes.
- pc_plus4 wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No overflow flag.

## Timing
- pc_out, imem_read, pend_* and state are registered. if_valid, flush_ifid, misalign and pc_plus4 are combinational from the current state and inputs.
- First fetch: imem_read = 1 one cycle after rst is released. On a hit, the first if_valid = 1 is in the same cycle.
- Hit redirect: 1 bubble; the target address is presented on the next cycle.
- Redirect during a miss: the target is presented 1 cycle after imem_busywait falls. The completing word is squashed.
- Sequential hit stream: one instruction per cycle, with pc_out advancing by 4 each cycle.

## Test plan
- Reset then hits: rst = 0 for 2 cycles, then 1, with imem_busywait = 0 -> pc_out sequence 0, 0, 4, 8, 0xC. if_valid = 1 from the first FETCH cycle.
- Miss: hold imem_busywait = 1 for 3 cycles at pc = 0x10 -> pc_out stays 0x10 and if_valid = 0 for 3 cycles. Next cycle if_valid = 1, then pc_out = 0x14.
- Redirect on hit: at pc = 0x20, branch_taken = 1 with branch_target = 0x100 -> flush_ifid = 1 that cycle, next pc_out = 0x100, misalign = 0.
- Redirect during miss, then a second redirect: busywait = 1 at pc = 0x40, branch to 0x200, then branch to 0x300 one cycle later, busywait falls 2 cycles after that -> pc_out holds 0x40, the returned word is squashed (if_valid = 0), next pc_out = 0x300.
- Stall, and stall with redirect: stall = 1 for 2 cycles at pc = 0x50 -> pc_out holds 0x50. stall = 1 with branch_taken = 1 to 0x83 -> next pc_out = 0x80, misalign pulses for 1 cycle.
- Wrap and reset mid-miss: pc = 0xFFFF_FFFC with a hit -> next pc_out = 0. Assert rst = 0 during MISS with pend_valid = 1 -> pc_out = RESET_VECTOR, pend cleared, no stale redirect applied afterwards.
